// File: rtl/bp_pkg.sv
// Shared constants, FSM state type and Q8.8 saturation helper for back_prop.
package bp_pkg;

    localparam int unsigned DW_DEF       = 16;
    localparam int unsigned FRAC_DEF     = 8;
    localparam int unsigned LR_SHIFT_DEF = 4;
    localparam int unsigned ACC_W        = 34;

    localparam logic signed [DW_DEF-1:0] ONE = 16'sh0100;

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (DW_DEF - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(1 << (DW_DEF - 1)));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ERR  = 2'd1,
        S_ROW  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Clamp a wide signed value into the DW-bit signed range.
    function automatic logic signed [DW_DEF-1:0] sat16(input logic signed [ACC_W-1:0] x);
        logic signed [DW_DEF-1:0] r;
        if (x > SAT_HI) begin
            r = DW_DEF'(SAT_HI);
        end else if (x < SAT_LO) begin
            r = DW_DEF'(SAT_LO);
        end else begin
            r = x[DW_DEF-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/bp_mac4.sv
// Four signed DW x DW multipliers feeding an ACC_W-bit adder tree.
module bp_mac4
    import bp_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) (
    input  logic signed [DW-1:0]    a_1,
    input  logic signed [DW-1:0]    a_2,
    input  logic signed [DW-1:0]    a_3,
    input  logic signed [DW-1:0]    a_4,
    input  logic signed [DW-1:0]    b_1,
    input  logic signed [DW-1:0]    b_2,
    input  logic signed [DW-1:0]    b_3,
    input  logic signed [DW-1:0]    b_4,
    output logic signed [2*DW-1:0]  p1_c,
    output logic signed [2*DW-1:0]  p2_c,
    output logic signed [2*DW-1:0]  p3_c,
    output logic signed [2*DW-1:0]  p4_c,
    output logic signed [ACC_W-1:0] sum_c
);

    localparam int unsigned PW = 2 * DW;

    // Full-precision products.
    assign p1_c = PW'(a_1) * PW'(b_1);
    assign p2_c = PW'(a_2) * PW'(b_2);
    assign p3_c = PW'(a_3) * PW'(b_3);
    assign p4_c = PW'(a_4) * PW'(b_4);

    // Sign-extended sum of the four products.
    assign sum_c = ACC_W'(p1_c) + ACC_W'(p2_c) + ACC_W'(p3_c) + ACC_W'(p4_c);

endmodule

// File: rtl/back_prop.sv
// Backward-propagation delta generator for the 9-5-4 Q-network.
// Optional hidden-error path (w3 row handshake, deltab2) enabled by BP_HIDDEN_EN.
module back_prop
    import bp_pkg::*;
#(
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned FRAC     = FRAC_DEF,
    parameter int unsigned LR_SHIFT = LR_SHIFT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic signed [DW-1:0] a2_1, a2_2, a2_3, a2_4, a2_5,
    input  logic signed [DW-1:0] a3_1, a3_2, a3_3, a3_4,
    input  logic signed [DW-1:0] t_1, t_2, t_3, t_4,
    output logic                 row_req,
    output logic [2:0]           row_idx,
    input  logic                 row_vld,
    input  logic signed [DW-1:0] w3_1, w3_2, w3_3, w3_4,
    output logic                 busy,
    output logic                 done,
    output logic signed [DW-1:0] deltaw3_11, deltaw3_12, deltaw3_13, deltaw3_14,
    output logic signed [DW-1:0] deltaw3_21, deltaw3_22, deltaw3_23, deltaw3_24,
    output logic signed [DW-1:0] deltaw3_31, deltaw3_32, deltaw3_33, deltaw3_34,
    output logic signed [DW-1:0] deltaw3_41, deltaw3_42, deltaw3_43, deltaw3_44,
    output logic signed [DW-1:0] deltaw3_51, deltaw3_52, deltaw3_53, deltaw3_54,
    output logic signed [DW-1:0] deltab3_1, deltab3_2, deltab3_3, deltab3_4,
    output logic signed [DW-1:0] deltab2_1, deltab2_2, deltab2_3, deltab2_4, deltab2_5
);

    localparam int unsigned PW = 2 * DW;

    state_t               state, state_n;
    logic [2:0]           j, j_n;
    logic                 row_ok_c;
    logic                 cap_c;

    logic signed [DW-1:0] a2_q  [5];
    logic signed [DW-1:0] a3_q  [4];
    logic signed [DW-1:0] t_q   [4];
    logic signed [DW-1:0] e_q   [4];
    logic signed [DW-1:0] dw3_q [5][4];
    logic signed [DW-1:0] db3_q [4];

    logic signed [DW-1:0]    a2_sel_c;
    logic signed [DW-1:0]    e_c   [4];
    logic signed [DW-1:0]    db3_c [4];
    logic signed [DW-1:0]    dw3_c [4];
    logic signed [PW-1:0]    lp_c  [4];
    logic signed [ACC_W-1:0] lane_sum_unused;

    // Next state, row counter and row capture strobe.
    always_comb begin
        state_n = state;
        j_n     = j;
        cap_c   = 1'b0;
        case (state)
            S_IDLE: if (start) state_n = S_ERR;
            S_ERR: begin
                state_n = S_ROW;
                j_n     = 3'd1;
            end
            S_ROW: if (row_ok_c) begin
                cap_c = 1'b1;
                if (j == 3'd5) begin
                    state_n = S_DONE;
                    j_n     = 3'd0;
                end else begin
                    j_n = j + 3'd1;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // State register and registered control outputs, derived from next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            j       <= 3'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            row_req <= 1'b0;
            row_idx <= 3'd0;
        end else begin
            state   <= state_n;
            j       <= j_n;
            busy    <= (state_n != S_IDLE);
            done    <= (state_n == S_DONE);
`ifdef BP_HIDDEN_EN
            row_req <= (state_n == S_ROW);
`else
            row_req <= 1'b0;
`endif
            row_idx <= (state_n == S_ROW) ? j_n : 3'd0;
        end
    end

    // Snapshot of activations and targets taken on an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) a2_q[i] <= '0;
            for (int k = 0; k < 4; k++) begin
                a3_q[k] <= '0;
                t_q[k]  <= '0;
            end
        end else if (state == S_IDLE && start) begin
            a2_q[0] <= a2_1; a2_q[1] <= a2_2; a2_q[2] <= a2_3;
            a2_q[3] <= a2_4; a2_q[4] <= a2_5;
            a3_q[0] <= a3_1; a3_q[1] <= a3_2; a3_q[2] <= a3_3; a3_q[3] <= a3_4;
            t_q[0]  <= t_1;  t_q[1]  <= t_2;  t_q[2]  <= t_3;  t_q[3]  <= t_4;
        end
    end

    // Hidden activation of the row being processed.
    always_comb begin
        a2_sel_c = '0;
        case (j)
            3'd1:    a2_sel_c = a2_q[0];
            3'd2:    a2_sel_c = a2_q[1];
            3'd3:    a2_sel_c = a2_q[2];
            3'd4:    a2_sel_c = a2_q[3];
            3'd5:    a2_sel_c = a2_q[4];
            default: a2_sel_c = '0;
        endcase
    end

    // Output error from the latched activations and targets.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            e_c[k] = sat16(ACC_W'(a3_q[k]) - ACC_W'(t_q[k]));
        end
    end

    // Output-bias and weight3 deltas; arithmetic shifts floor toward -inf.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            db3_c[k] = sat16(-(ACC_W'(e_c[k]) >>> LR_SHIFT));
            dw3_c[k] = sat16(-ACC_W'(lp_c[k] >>> (FRAC + LR_SHIFT)));
        end
    end

    bp_mac4 #(.DW(DW)) u_lane_mac (
        .a_1 (a2_sel_c), .a_2 (a2_sel_c), .a_3 (a2_sel_c), .a_4 (a2_sel_c),
        .b_1 (e_q[0]),   .b_2 (e_q[1]),   .b_3 (e_q[2]),   .b_4 (e_q[3]),
        .p1_c(lp_c[0]),  .p2_c(lp_c[1]),  .p3_c(lp_c[2]),  .p4_c(lp_c[3]),
        .sum_c(lane_sum_unused)
    );

`ifdef BP_HIDDEN_EN
    logic signed [PW-1:0]    wp_unused [4];
    logic signed [ACC_W-1:0] wsum_c;
    logic signed [ACC_W-1:0] s_c;
    logic signed [DW-1:0]    db2_c;
    logic signed [DW-1:0]    db2_q [5];

    assign row_ok_c = row_vld;

    bp_mac4 #(.DW(DW)) u_w3_mac (
        .a_1 (w3_1),         .a_2 (w3_2),         .a_3 (w3_3),         .a_4 (w3_4),
        .b_1 (e_q[0]),       .b_2 (e_q[1]),       .b_3 (e_q[2]),       .b_4 (e_q[3]),
        .p1_c(wp_unused[0]), .p2_c(wp_unused[1]), .p3_c(wp_unused[2]), .p4_c(wp_unused[3]),
        .sum_c(wsum_c)
    );

    // Back-propagated error with ReLU derivative gate (a2 must be strictly positive).
    assign s_c   = wsum_c >>> FRAC;
    assign db2_c = (!a2_sel_c[DW-1] && (a2_sel_c != '0)) ? sat16(-(s_c >>> LR_SHIFT)) : '0;

    // Hidden-bias delta for the captured row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 5; r++) db2_q[r] <= '0;
        end else begin
            for (int r = 0; r < 5; r++) begin
                if (cap_c && j == 3'(r + 1)) db2_q[r] <= db2_c;
            end
        end
    end

    assign deltab2_1 = db2_q[0];
    assign deltab2_2 = db2_q[1];
    assign deltab2_3 = db2_q[2];
    assign deltab2_4 = db2_q[3];
    assign deltab2_5 = db2_q[4];
`else
    logic unused_row;

    assign row_ok_c   = 1'b1;
    assign unused_row = ^{row_vld, w3_1, w3_2, w3_3, w3_4};

    assign deltab2_1 = '0;
    assign deltab2_2 = '0;
    assign deltab2_3 = '0;
    assign deltab2_4 = '0;
    assign deltab2_5 = '0;
`endif

    // Error register and deltas; each updates only in its own step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                e_q[k]   <= '0;
                db3_q[k] <= '0;
            end
            for (int r = 0; r < 5; r++) begin
                for (int k = 0; k < 4; k++) dw3_q[r][k] <= '0;
            end
        end else begin
            if (state == S_ERR) begin
                for (int k = 0; k < 4; k++) begin
                    e_q[k]   <= e_c[k];
                    db3_q[k] <= db3_c[k];
                end
            end
            for (int r = 0; r < 5; r++) begin
                if (cap_c && j == 3'(r + 1)) begin
                    for (int k = 0; k < 4; k++) dw3_q[r][k] <= dw3_c[k];
                end
            end
        end
    end

    assign deltaw3_11 = dw3_q[0][0]; assign deltaw3_12 = dw3_q[0][1];
    assign deltaw3_13 = dw3_q[0][2]; assign deltaw3_14 = dw3_q[0][3];
    assign deltaw3_21 = dw3_q[1][0]; assign deltaw3_22 = dw3_q[1][1];
    assign deltaw3_23 = dw3_q[1][2]; assign deltaw3_24 = dw3_q[1][3];
    assign deltaw3_31 = dw3_q[2][0]; assign deltaw3_32 = dw3_q[2][1];
    assign deltaw3_33 = dw3_q[2][2]; assign deltaw3_34 = dw3_q[2][3];
    assign deltaw3_41 = dw3_q[3][0]; assign deltaw3_42 = dw3_q[3][1];
    assign deltaw3_43 = dw3_q[3][2]; assign deltaw3_44 = dw3_q[3][3];
    assign deltaw3_51 = dw3_q[4][0]; assign deltaw3_52 = dw3_q[4][1];
    assign deltaw3_53 = dw3_q[4][2]; assign deltaw3_54 = dw3_q[4][3];

    assign deltab3_1 = db3_q[0];
    assign deltab3_2 = db3_q[1];
    assign deltab3_3 = db3_q[2];
    assign deltab3_4 = db3_q[3];

endmodule

// File: tb/tb_back_prop.sv
// Self-checking bench for back_prop: directed passes, scoreboard of expected deltas.
module tb_back_prop;
    import bp_pkg::*;

`ifdef BP_HIDDEN_EN
    localparam bit HID = 1'b1;
`else
    localparam bit HID = 1'b0;
`endif

    typedef struct {
        logic [15:0] dw3 [20];
        logic [15:0] db3 [4];
        logic [15:0] db2 [5];
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, start, row_vld;
    logic        row_req, busy, done;
    logic [2:0]  row_idx;
    logic [15:0] a2_in [5];
    logic [15:0] a3_in [4];
    logic [15:0] t_in  [4];
    logic [15:0] w3_in [4];
    logic [15:0] dw3_o [20];
    logic [15:0] db3_o [4];
    logic [15:0] db2_o [5];

    logic [15:0] a2s [5];
    logic [15:0] a3s [4];
    logic [15:0] ts  [4];
    logic [15:0] w3t [5][4];

    exp_t sb [$];
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    back_prop dut (
        .clk(clk), .rst(rst), .start(start),
        .a2_1(a2_in[0]), .a2_2(a2_in[1]), .a2_3(a2_in[2]), .a2_4(a2_in[3]), .a2_5(a2_in[4]),
        .a3_1(a3_in[0]), .a3_2(a3_in[1]), .a3_3(a3_in[2]), .a3_4(a3_in[3]),
        .t_1(t_in[0]), .t_2(t_in[1]), .t_3(t_in[2]), .t_4(t_in[3]),
        .row_req(row_req), .row_idx(row_idx), .row_vld(row_vld),
        .w3_1(w3_in[0]), .w3_2(w3_in[1]), .w3_3(w3_in[2]), .w3_4(w3_in[3]),
        .busy(busy), .done(done),
        .deltaw3_11(dw3_o[0]),  .deltaw3_12(dw3_o[1]),  .deltaw3_13(dw3_o[2]),  .deltaw3_14(dw3_o[3]),
        .deltaw3_21(dw3_o[4]),  .deltaw3_22(dw3_o[5]),  .deltaw3_23(dw3_o[6]),  .deltaw3_24(dw3_o[7]),
        .deltaw3_31(dw3_o[8]),  .deltaw3_32(dw3_o[9]),  .deltaw3_33(dw3_o[10]), .deltaw3_34(dw3_o[11]),
        .deltaw3_41(dw3_o[12]), .deltaw3_42(dw3_o[13]), .deltaw3_43(dw3_o[14]), .deltaw3_44(dw3_o[15]),
        .deltaw3_51(dw3_o[16]), .deltaw3_52(dw3_o[17]), .deltaw3_53(dw3_o[18]), .deltaw3_54(dw3_o[19]),
        .deltab3_1(db3_o[0]), .deltab3_2(db3_o[1]), .deltab3_3(db3_o[2]), .deltab3_4(db3_o[3]),
        .deltab2_1(db2_o[0]), .deltab2_2(db2_o[1]), .deltab2_3(db2_o[2]),
        .deltab2_4(db2_o[3]), .deltab2_5(db2_o[4])
    );

    function automatic logic [15:0] satm(input longint x);
        if (x > 32767)  return 16'h7FFF;
        if (x < -32768) return 16'h8000;
        return 16'(x);
    endfunction

    function automatic longint sx(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    // Reference arithmetic built from the stimulus arrays.
    function automatic exp_t model();
        exp_t   r;
        longint e [4];
        longint p, s;
        for (int k = 0; k < 4; k++) begin
            e[k]     = sx(satm(sx(a3s[k]) - sx(ts[k])));
            r.db3[k] = satm(-(e[k] >>> LR_SHIFT_DEF));
        end
        for (int j = 0; j < 5; j++) begin
            s = 0;
            for (int k = 0; k < 4; k++) begin
                p = sx(a2s[j]) * e[k];
                r.dw3[j*4+k] = satm(-(p >>> (FRAC_DEF + LR_SHIFT_DEF)));
                s = s + sx(w3t[j][k]) * e[k];
            end
            s = s >>> FRAC_DEF;
            r.db2[j] = (HID && sx(a2s[j]) > 0) ? satm(-(s >>> LR_SHIFT_DEF)) : 16'h0000;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_row_req"}, row_req, 0);
        check({tag, "_row_idx"}, row_idx, 0);
        for (int i = 0; i < 20; i++) check($sformatf("%s_dw3_%0d", tag, i), dw3_o[i], 0);
        for (int i = 0; i < 4; i++)  check($sformatf("%s_db3_%0d", tag, i), db3_o[i], 0);
        for (int i = 0; i < 5; i++)  check($sformatf("%s_db2_%0d", tag, i), db2_o[i], 0);
    endtask

    task automatic clear_stim();
        for (int i = 0; i < 5; i++) begin
            a2s[i] = 16'h0000;
            for (int k = 0; k < 4; k++) w3t[i][k] = 16'($urandom);
        end
        for (int k = 0; k < 4; k++) begin
            a3s[k] = 16'h0000;
            ts[k]  = 16'h0000;
        end
    endtask

    task automatic run_pass(input int stall_row, input int stall_n, input int abort_row);
        exp_t ex;
        int   exp_row, stalled, lat;
        bit   seen;
        ex = model();
        @(negedge clk);
        for (int i = 0; i < 5; i++) a2_in[i] = a2s[i];
        for (int k = 0; k < 4; k++) begin
            a3_in[k] = a3s[k];
            t_in[k]  = ts[k];
        end
        start = 1'b1;
        if (abort_row == 0) sb.push_back(ex);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) a2_in[i] = 16'($urandom);
        for (int k = 0; k < 4; k++) begin
            a3_in[k] = 16'($urandom);
            t_in[k]  = 16'($urandom);
        end
        exp_row = 1; stalled = 0; lat = 0; seen = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("busy_err", busy, 1);
                check("row_req_err", row_req, 0);
            end
            if (done) begin
                seen = 1'b1;
                lat  = c;
            end else if (c >= 2) begin
                check("busy_row", busy, 1);
                check("row_req", row_req, HID);
                check("row_idx", row_idx, exp_row);
                if (abort_row == exp_row) begin
                    start = 1'b0;
                    rst   = 1'b1;
                    #1;
                    check_zero("abort");
                    @(negedge clk);
                    rst = 1'b0;
                    return;
                end
            end
            start = (c == 3);
            if (c >= 2 && exp_row <= 5) begin
                if (exp_row == stall_row && stalled < stall_n) begin
                    row_vld = 1'b0;
                    for (int k = 0; k < 4; k++) w3_in[k] = 16'($urandom);
                    stalled++;
                    if (!HID) exp_row++;
                end else begin
                    row_vld = 1'b1;
                    for (int k = 0; k < 4; k++) w3_in[k] = w3t[exp_row-1][k];
                    exp_row++;
                end
            end
        end
        check("done_lat", lat, 7 + (HID ? stall_n : 0));
        @(negedge clk);
        start = 1'b0;
        check("busy_after", busy, 0);
        check("done_after", done, 0);
        if (sb.size() > 0) begin
            ex = sb.pop_front();
            for (int i = 0; i < 20; i++)
                check($sformatf("dw3_%0d%0d", i/4 + 1, i%4 + 1), dw3_o[i], ex.dw3[i]);
            for (int i = 0; i < 4; i++) check($sformatf("db3_%0d", i + 1), db3_o[i], ex.db3[i]);
            for (int i = 0; i < 5; i++) check($sformatf("db2_%0d", i + 1), db2_o[i], ex.db2[i]);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; row_vld = 1'b0;
        for (int i = 0; i < 5; i++) a2_in[i] = '0;
        for (int k = 0; k < 4; k++) begin
            a3_in[k] = '0; t_in[k] = '0; w3_in[k] = '0;
        end
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_zero("idle");

        // Output error
        clear_stim();
        a3s[0] = 16'h0200; ts[0] = ONE; a2s[0] = 16'h0200;
        run_pass(0, 0, 0);
        check("s1_db3_1", db3_o[0], 16'hFFF0);
        check("s1_dw3_11", dw3_o[0], 16'hFFE0);

        // Hidden error with ReLU gate
        clear_stim();
        for (int k = 0; k < 4; k++) begin
            a3s[k] = 16'h0200; ts[k] = ONE; w3t[1][k] = ONE;
        end
        a2s[0] = 16'h0300; a2s[1] = ONE; a2s[2] = 16'hFF00; a2s[3] = 16'h0080;
        run_pass(0, 0, 0);
        check("s2_db2_2", db2_o[1], HID ? 16'hFFC0 : 16'h0000);
        check("s2_db2_3", db2_o[2], 16'h0000);

        // Stall on row 2, same stimulus
        run_pass(2, 3, 0);
        check("s4_db2_2", db2_o[1], HID ? 16'hFFC0 : 16'h0000);

        // Saturation
        clear_stim();
        a3s[0] = 16'h7FFF; ts[0] = 16'h8000; a2s[0] = 16'h7FFF;
        a3s[1] = 16'h8000; ts[1] = 16'h7FFF; a2s[1] = 16'h8000;
        for (int k = 0; k < 4; k++) w3t[0][k] = 16'h7FFF;
        run_pass(0, 0, 0);
        check("s3_db3_1", db3_o[0], 16'hF801);
        check("s3_dw3_11", dw3_o[0], 16'h8000);
        check("s3_db3_2", db3_o[1], 16'h0800);

        // Random patterns
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 5; i++) begin
                a2s[i] = 16'($urandom);
                for (int k = 0; k < 4; k++) w3t[i][k] = 16'($urandom);
            end
            for (int k = 0; k < 4; k++) begin
                a3s[k] = 16'($urandom); ts[k] = 16'($urandom);
            end
            run_pass(0, 0, 0);
        end

        // Reset during row 3, then a clean pass
        run_pass(0, 0, 3);
        clear_stim();
        a3s[0] = 16'h0200; ts[0] = ONE; a2s[0] = 16'h0200;
        run_pass(0, 0, 0);
        check("s6_db3_1", db3_o[0], 16'hFFF0);
        check("s6_dw3_11", dw3_o[0], 16'hFFE0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/back_prop.md
# back_prop

Backward-propagation delta generator for the 9-5-4 Q-network. It takes the latched hidden activations (a2), the output activations (a3) and the training targets, and produces the update terms deltaw3 (5×4), deltab3 (4) and deltab2 (5). These terms are consumed by the weight and bias update path. Hidden-layer error is computed one weight3 row per step, with w3 rows fetched through a request/valid handshake from the weight3 store.

## Interface
Parameters:
- DW, 16, data width; all values signed Q8.8
- FRAC, 8, fractional bits
- LR_SHIFT, 4, learning rate = 2^-LR_SHIFT

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  sampled in IDLE only; latches a2, a3 and t, then begins a pass
- a2_1..a2_5  in  DW each  hidden activations
- a3_1..a3_4  in  DW each  output activations
- t_1..t_4  in  DW each  targets
- row_req  out  1  requests weight3 row row_idx
- row_idx  out  3  row index, 1..5 (0 when idle)
- row_vld  in  1  w3 row valid; sampled only while row_req=1
- w3_1..w3_4  in  DW each  weight3 row data, captured when row_req&row_vld
- busy  out  1  high from ERR through DONE inclusive
- done  out  1  one-cycle pulse in DONE
- deltaw3_jk (j=1..5, k=1..4)  out  DW each  registered
- deltab3_1..deltab3_4  out  DW each  registered
- deltab2_1..deltab2_5  out  DW each  registered

## Operation
- FSM states: IDLE, ERR, ROW, DONE.
  - IDLE→ERR when start=1.
  - ERR→ROW with j=1.
  - ROW: stays in ROW while row_vld=0. On row_vld=1, row j is processed; then j++, or →DONE if j=5.
  - DONE→IDLE.
- ERR:
  - e_k = sat(a3_k − t_k), held in an internal register.
  - deltab3_k = sat(−(e_k >>> LR_SHIFT)).
- ROW j (on capture):
  - deltaw3_jk = sat(−((a2_j·e_k) >>> (FRAC+LR_SHIFT))), k=1..4.
  - s_j = (Σ_k w3_k·e_k) >>> FRAC, with a 34-bit accumulator.
  - deltab2_j = (a2_j > 0) ? sat(−(s_j >>> LR_SHIFT)) : 0. This is the ReLU derivative gate; a2_j = 0 gates to 0.
- Arithmetic rules:
  - Products are full 32-bit signed.
  - Shifts are arithmetic, i.e. truncation toward −inf.
  - sat clamps to [0x8000, 0x7FFF]; −(−32768) saturates to 0x7FFF.
- Delta outputs hold their values until overwritten by the next pass; each register updates only in its own step.
- start while busy: ignored.
- row_vld outside ROW: ignored.
- Changes to a2, a3 or t after the start edge have no effect on the pass.

## Timing
- Reset value of every output (all deltas, busy, done, row_req, row_idx): 0. State resets to IDLE.
- start sampled at edge N:
  - ERR occupies cycle N+1.
  - ROW j=1 starts at cycle N+2; row_req=1 and row_idx=j are registered outputs.
  - With row_vld held at 1, rows occupy N+2..N+6 and done=1 in N+7. busy=0 from N+8.
- Each cycle row_vld=0 in ROW adds one cycle; row_req and row_idx stay stable while stalled.
- rst mid-pass: immediate return to IDLE and all outputs 0; the next start runs a clean pass.

## Configuration
- BP_HIDDEN_EN defined:
  - hidden-error path, row handshake and deltab2 outputs are present as above.
- BP_HIDDEN_EN undefined:
  - row_req is tied 0 and row_vld/w3 are ignored.
  - ROW advances one row per cycle unconditionally, so done still arrives at N+7.
  - deltab2_* are tied 0 and the accumulator/MAC lanes for s_j are removed.
  - deltaw3 and deltab3 are unchanged.

## Structure
- Package bp_pkg:
  - DW, FRAC and LR_SHIFT defaults
  - state enum
  - sat16 function (wide signed → DW)
  - Q8.8 ONE constant 0x0100
- Sub-module bp_mac4: four signed multipliers plus adder tree. Reused for the a2_j·e_k lanes and the w3·e sum (two instances).

## Test plan
- Output error:
  - Stimulus: a3_1=0x0200, t_1=0x0100, a2_1=0x0200, others 0.
  - Response: deltab3_1=0xFFF0, deltaw3_11=0xFFE0, and done at N+7.
- Hidden error:
  - Stimulus: e_k=0x0100 for all k, row2 w3=0x0100 ×4, a2_2=0x0100, a2_3=0xFF00.
  - Response: deltab2_2=0xFFC0 and deltab2_3=0x0000.
- Saturation:
  - Stimulus: a3_1=0x7FFF, t_1=0x8000, a2_1=0x7FFF.
  - Response: e_1=0x7FFF, deltab3_1=0xF801, deltaw3_11=0x8000.
- Stall:
  - Stimulus: row_vld=0 for 3 cycles on row 2.
  - Response: row_req=1 and row_idx=2 held for the stall, done at N+10, deltas identical to the no-stall run.
- Control robustness:
  - Stimulus: start pulsed at N+3 is ignored (single done). Then rst asserted during row 3.
  - Response: all outputs 0 and busy=0 immediately; a subsequent start gives the correct results.
- BP_HIDDEN_EN undefined, scenario 1 stimulus:
  - Response: row_req never asserted, deltab2_*=0, same deltaw3 and deltab3 values, done at N+7.
